// File: rtl/inst_boot_loader.sv
// rtl/inst_boot_loader.sv - stream-fed instruction memory loader with zero fill and core reset hold
module inst_boot_loader #(
    parameter int unsigned DATA_W              = 32,
    parameter int unsigned ADDR_W              = 32,
    parameter int unsigned DEPTH               = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
    parameter int unsigned ADDR_STEP           = 4,
    parameter int unsigned ZERO_FILL           = 1,
    parameter int unsigned RELEASE_DLY         = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         s_valid,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [ADDR_W-1:0]            Inst_addr_load,
    output logic [DATA_W-1:0]            Inst_load,
    output logic                         load_en,
    output logic                         core_rst_n,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   word_cnt,
    output logic [DATA_W-1:0]            checksum,
    output logic                         err_overflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned DLY_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((RELEASE_DLY > 0) ? RELEASE_DLY - 1 : 0);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_WAIT,
        ST_RUN
    } state_t;

    // With no settle delay the final write edge hands control straight to the core.
    localparam state_t AFTER_WR = (RELEASE_DLY == 0) ? ST_RUN : ST_WAIT;

    state_t              r_state;
    logic [CNT_W-1:0]    r_idx;
    logic [DLY_W-1:0]    r_dly;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_load_en;
    logic                r_core_rst_n;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [DATA_W-1:0]   r_checksum;
    logic                r_err_overflow;

    logic                w_accept;
    logic                w_idx_last;
    logic [ADDR_W-1:0]   w_addr;

    assign s_ready    = (r_state == ST_LOAD);
    assign w_accept   = s_valid && s_ready;
    assign w_idx_last = (r_idx == IDX_LAST);
    assign w_addr     = BASE_ADDR + ADDR_W'(r_idx) * ADDR_W'(ADDR_STEP);

    assign Inst_addr_load = r_addr;
    assign Inst_load      = r_data;
    assign load_en        = r_load_en;
    assign core_rst_n     = r_core_rst_n;
    assign busy           = r_busy;
    assign done           = r_done;
    assign word_cnt       = r_word_cnt;
    assign checksum       = r_checksum;
    assign err_overflow   = r_err_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_dly          <= '0;
            r_addr         <= BASE_ADDR;
            r_data         <= '0;
            r_load_en      <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_word_cnt     <= '0;
            r_checksum     <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            r_load_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state        <= ST_LOAD;
                        r_busy         <= 1'b1;
                        r_idx          <= '0;
                        r_word_cnt     <= '0;
                        r_checksum     <= '0;
                        r_err_overflow <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_load_en  <= 1'b1;
                        r_addr     <= w_addr;
                        r_data     <= s_data;
                        r_idx      <= r_idx + CNT_W'(1);
                        r_word_cnt <= r_word_cnt + CNT_W'(1);
                        r_checksum <= r_checksum + s_data;
                        if (w_idx_last || (s_last && ZERO_FILL == 0)) begin
                            // Memory is full without an end marker: stop accepting and flag it.
                            if (w_idx_last && !s_last) begin
                                r_err_overflow <= 1'b1;
                            end
                            r_state <= AFTER_WR;
                            r_dly   <= '0;
                            if (AFTER_WR == ST_RUN) begin
                                r_core_rst_n <= 1'b1;
                                r_done       <= 1'b1;
                                r_busy       <= 1'b0;
                            end
                        end else if (s_last) begin
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    r_load_en <= 1'b1;
                    r_addr    <= w_addr;
                    r_data    <= '0;
                    r_idx     <= r_idx + CNT_W'(1);
                    if (w_idx_last) begin
                        r_state <= AFTER_WR;
                        r_dly   <= '0;
                        if (AFTER_WR == ST_RUN) begin
                            r_core_rst_n <= 1'b1;
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_dly == DLY_LAST) begin
                        r_state      <= ST_RUN;
                        r_core_rst_n <= 1'b1;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_dly <= r_dly + DLY_W'(1);
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        r_state        <= ST_LOAD;
                        r_core_rst_n   <= 1'b0;
                        r_done         <= 1'b0;
                        r_busy         <= 1'b1;
                        r_idx          <= '0;
                        r_word_cnt     <= '0;
                        r_checksum     <= '0;
                        r_err_overflow <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_boot_loader.sv
// tb/tb_inst_boot_loader.sv - directed checks of inst_boot_loader on a fill config and an overflow config
module tb_inst_boot_loader;

    logic clk;
    logic rst_n;

    logic        a_start, a_valid, a_last;
    logic [31:0] a_data;
    logic        a_s_ready, a_load_en, a_core_rst_n, a_busy, a_done, a_err;
    logic [31:0] a_addr, a_inst, a_checksum;
    logic [3:0]  a_word_cnt;

    logic        b_start, b_valid, b_last;
    logic [31:0] b_data;
    logic        b_s_ready, b_load_en, b_core_rst_n, b_busy, b_done, b_err;
    logic [31:0] b_addr, b_inst, b_checksum;
    logic [2:0]  b_word_cnt;

    inst_boot_loader #(
        .DEPTH(8), .ZERO_FILL(1), .RELEASE_DLY(2)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .s_valid(a_valid), .s_data(a_data), .s_last(a_last), .s_ready(a_s_ready),
        .Inst_addr_load(a_addr), .Inst_load(a_inst), .load_en(a_load_en),
        .core_rst_n(a_core_rst_n), .busy(a_busy), .done(a_done),
        .word_cnt(a_word_cnt), .checksum(a_checksum), .err_overflow(a_err)
    );

    inst_boot_loader #(
        .DEPTH(4), .ZERO_FILL(0), .RELEASE_DLY(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .s_valid(b_valid), .s_data(b_data), .s_last(b_last), .s_ready(b_s_ready),
        .Inst_addr_load(b_addr), .Inst_load(b_inst), .load_en(b_load_en),
        .core_rst_n(b_core_rst_n), .busy(b_busy), .done(b_done),
        .word_cnt(b_word_cnt), .checksum(b_checksum), .err_overflow(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_miss;
    int cyc;
    int sel;
    int rise_cyc;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];
    logic [31:0] e_addr[$];
    logic [31:0] e_data[$];
    int          e_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete(); q_data.delete(); q_cyc.delete();
        e_addr.delete(); e_data.delete(); e_cyc.delete();
        rise_cyc = -1;
    endtask

    task automatic step();
        logic       le, crn;
        logic [31:0] ad, dt;
        @(posedge clk);
        #1;
        cyc++;
        le  = (sel == 0) ? a_load_en : b_load_en;
        ad  = (sel == 0) ? a_addr : b_addr;
        dt  = (sel == 0) ? a_inst : b_inst;
        crn = (sel == 0) ? a_core_rst_n : b_core_rst_n;
        if (le) begin
            q_addr.push_back(ad);
            q_data.push_back(dt);
            q_cyc.push_back(cyc);
        end
        if (crn && rise_cyc < 0) rise_cyc = cyc;
    endtask

    task automatic expect_wr(input logic [31:0] ad, input logic [31:0] dt, input int c);
        e_addr.push_back(ad);
        e_data.push_back(dt);
        e_cyc.push_back(c);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        chk($sformatf("%s_nwrites", tag), q_addr.size(), e_addr.size());
        n = (q_addr.size() < e_addr.size()) ? q_addr.size() : e_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), q_addr[i], e_addr[i]);
            chk($sformatf("%s_data%0d", tag, i), q_data[i], e_data[i]);
            chk($sformatf("%s_cyc%0d", tag, i), q_cyc[i], e_cyc[i]);
        end
    endtask

    logic [31:0] prog[4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};
    logic [31:0] bp[4]   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'hF0000001};
    logic [31:0] ovf[6]  = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005, 32'hF0000006};
    int          pat[7]  = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        int          idx;
        int          w;
        int          last_wr;
        logic        acc;
        logic [31:0] sum;

        n_vec = 0; n_miss = 0; cyc = 0; sel = 0; rise_cyc = -1;
        rst_n = 1'b0;
        a_start = 0; a_valid = 0; a_last = 0; a_data = '0;
        b_start = 0; b_valid = 0; b_last = 0; b_data = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load_en", a_load_en, 1'b0);
        chk("rst_core_rst_n", a_core_rst_n, 1'b0);
        chk("rst_s_ready", a_s_ready, 1'b0);
        chk("rst_word_cnt", a_word_cnt, 4'd0);
        chk("rst_addr", a_addr, 32'd0);
        chk("rst_busy_done", {a_busy, a_done, a_err}, 3'b000);
        chk("rst_b_load_en", b_load_en, 1'b0);
        rst_n = 1'b1;
        step(); step();
        chk("idle_s_ready", a_s_ready, 1'b0);

        // Back-to-back program with zero fill
        clear_log();
        a_start = 1; step(); a_start = 0;
        chk("t2_busy", a_busy, 1'b1);
        chk("t2_s_ready", a_s_ready, 1'b1);
        idx = 0; sum = '0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_data = prog[i]; a_last = (i == 3);
            acc = a_s_ready;
            step();
            if (acc) begin
                expect_wr(32'(idx * 4), prog[i], cyc);
                idx++; sum += prog[i];
            end
        end
        a_valid = 0; a_last = 0;
        chk("t2_accepted", idx, 4);
        chk("t2_s_ready_fill", a_s_ready, 1'b0);
        last_wr = cyc;
        for (int k = idx; k < 8; k++) expect_wr(32'(k * 4), 32'd0, last_wr + (k - idx + 1));
        repeat (16) step();
        compare_writes("t2");
        chk("t2_word_cnt", a_word_cnt, 4'd4);
        chk("t2_checksum", a_checksum, sum);
        chk("t2_release_cyc", rise_cyc, last_wr + 4 + 2);
        chk("t2_run", {a_core_rst_n, a_done, a_busy, a_err}, 4'b1100);

        // Restart from RUN, then backpressured stream
        clear_log();
        a_start = 1; step(); a_start = 0;
        chk("t5_core_rst_n", a_core_rst_n, 1'b0);
        chk("t5_done", a_done, 1'b0);
        chk("t5_word_cnt", a_word_cnt, 4'd0);
        chk("t5_checksum", a_checksum, 32'd0);
        idx = 0; w = 0; sum = '0;
        for (int j = 0; j < 7; j++) begin
            a_valid = pat[j][0];
            a_data  = (pat[j] != 0) ? bp[w] : 32'hDEADBEEF;
            a_last  = (pat[j] != 0) && (w == 3);
            acc = a_valid && a_s_ready;
            step();
            if (acc) begin
                expect_wr(32'(idx * 4), bp[w], cyc);
                idx++; sum += bp[w]; w++;
            end
        end
        a_valid = 0; a_last = 0;
        chk("t3_accepted", idx, 4);
        last_wr = e_cyc[e_cyc.size() - 1];
        for (int k = idx; k < 8; k++) expect_wr(32'(k * 4), 32'd0, last_wr + (k - idx + 1));
        repeat (16) step();
        compare_writes("t3");
        chk("t3_word_cnt", a_word_cnt, 4'd4);
        chk("t3_checksum", a_checksum, sum);
        chk("t3_done", a_done, 1'b1);

        // Overflow on the 4-deep, no-fill instance
        sel = 1;
        clear_log();
        b_start = 1; step(); b_start = 0;
        idx = 0; sum = '0;
        for (int i = 0; i < 6; i++) begin
            b_valid = 1; b_data = ovf[i]; b_last = 0;
            acc = b_s_ready;
            step();
            if (acc) begin
                expect_wr(32'(idx * 4), ovf[i], cyc);
                idx++; sum += ovf[i];
            end
            if (i == 3) begin
                chk("t4_s_ready_after4", b_s_ready, 1'b0);
                chk("t4_err", b_err, 1'b1);
                last_wr = cyc;
            end
        end
        b_valid = 0;
        repeat (4) step();
        chk("t4_accepted", idx, 4);
        compare_writes("t4");
        chk("t4_word_cnt", b_word_cnt, 3'd4);
        chk("t4_checksum", b_checksum, sum);
        chk("t4_release_cyc", rise_cyc, last_wr + 2);
        chk("t4_run", {b_core_rst_n, b_done, b_busy, b_err}, 4'b1101);

        // Asynchronous reset in the middle of a load
        sel = 0;
        clear_log();
        a_start = 1; step(); a_start = 0;
        for (int i = 0; i < 2; i++) begin
            a_valid = 1; a_data = prog[i]; a_last = 0;
            step();
        end
        chk("t6_pre_load_en", a_load_en, 1'b1);
        chk("t6_pre_word_cnt", a_word_cnt, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_load_en", a_load_en, 1'b0);
        chk("t6_word_cnt", a_word_cnt, 4'd0);
        chk("t6_addr", a_addr, 32'd0);
        chk("t6_data", a_inst, 32'd0);
        chk("t6_flags", {a_core_rst_n, a_s_ready, a_busy, a_done, a_checksum}, 36'd0);
        a_valid = 0;
        step();
        rst_n = 1'b1;
        step();
        clear_log();
        a_start = 1; step(); a_start = 0;
        a_valid = 1; a_data = prog[2]; a_last = 1;
        step();
        a_valid = 0; a_last = 0;
        chk("t6_reload_en", a_load_en, 1'b1);
        chk("t6_reload_addr", a_addr, 32'd0);
        chk("t6_reload_data", a_inst, prog[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
